alu_display: RTL and testbench

ALU_DISPLAY -- requirements
Module: alu_display

---
 rtl/alu_display_pkg.sv | 39 +++
 rtl/alu_display_hex7seg.sv | 38 +++
 rtl/alu_display.sv | 143 ++++++++++++++
 tb/tb_alu_display.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_display_pkg
// Description : Shared constants for the ALU result display: active-low
//               seven-segment glyphs ([6:0] = g..a), blank/off codes and
//               the anode select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_display_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;  // lower-case b
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;  // lower-case d
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // All seven segments dark (cathodes are active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // All four digit anodes off (active-low)
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low one-hot anode pattern for a digit index
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage : alu_display_pkg
`default_nettype wire

// File: rtl/alu_display_hex7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex7seg
// Description : Combinational hex nibble to active-low seven-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
  import alu_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Glyph lookup
  always_comb begin
    o_seg = GLYPH_0;
    case (i_nibble)
      4'h0:    o_seg = GLYPH_0;
      4'h1:    o_seg = GLYPH_1;
      4'h2:    o_seg = GLYPH_2;
      4'h3:    o_seg = GLYPH_3;
      4'h4:    o_seg = GLYPH_4;
      4'h5:    o_seg = GLYPH_5;
      4'h6:    o_seg = GLYPH_6;
      4'h7:    o_seg = GLYPH_7;
      4'h8:    o_seg = GLYPH_8;
      4'h9:    o_seg = GLYPH_9;
      4'hA:    o_seg = GLYPH_A;
      4'hB:    o_seg = GLYPH_B;
      4'hC:    o_seg = GLYPH_C;
      4'hD:    o_seg = GLYPH_D;
      4'hE:    o_seg = GLYPH_E;
      default: o_seg = GLYPH_F;
    endcase
  end

endmodule : hex7seg
`default_nettype wire

// File: rtl/alu_display.sv
`default_nettype none
// ============================================================================
// Module      : alu_display
// Description : Captures a CPU ALU result plus ZF/OF into a shadow register
//               and scans one 16-bit half of it onto a 4-digit multiplexed
//               seven-segment display, with optional leading-zero blanking
//               and flag decimal points. The shown value only changes at
//               frame boundaries so a frame is never torn.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_display
  import alu_display_pkg::*;
#(
  parameter int REFRESH_DIV = 65536,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ALU_OUT,
  input  logic        ALU_ZF,
  input  logic        ALU_OF,
  input  logic        LOAD,
  input  logic        FREEZE,
  input  logic        HALF,
  output logic [7:0]  SEG,
  output logic [3:0]  AN
);

  localparam int                 c_cnt_w    = $clog2(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);

  logic [c_cnt_w-1:0] r_refresh_cnt;
  logic [1:0]         r_digit_idx;
  logic [31:0]        r_shadow_word;
  logic               r_shadow_zf;
  logic               r_shadow_of;
  logic [15:0]        r_frame_word;
  logic               r_frame_zf;
  logic               r_frame_of;

  logic               w_slot_wrap;
  logic               w_frame_wrap;
  logic [3:0]         w_nibble;
  logic               w_upper_zero;
  logic [6:0]         w_glyph;
  logic               w_dp_n;
  logic [7:0]         w_seg_next;
  logic [3:0]         w_an_next;

  assign w_slot_wrap  = (r_refresh_cnt == c_cnt_last);
  assign w_frame_wrap = w_slot_wrap && (r_digit_idx == 2'd3);

  // Shadow capture of the ALU result and flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shadow_word <= 32'h0;
      r_shadow_zf   <= 1'b0;
      r_shadow_of   <= 1'b0;
    end else if (LOAD && !FREEZE) begin
      r_shadow_word <= ALU_OUT;
      r_shadow_zf   <= ALU_ZF;
      r_shadow_of   <= ALU_OF;
    end
  end

  // Refresh counter and digit index; each digit owns REFRESH_DIV cycles
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 2'd0;
    end else if (w_slot_wrap) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= r_digit_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + c_cnt_w'(1);
    end
  end

  // Frame latch: the selected shadow half and flags are sampled only as
  // digit 3 hands over to digit 0, using the shadow from before this edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_frame_word <= 16'h0;
      r_frame_zf   <= 1'b0;
      r_frame_of   <= 1'b0;
    end else if (w_frame_wrap) begin
      r_frame_word <= HALF ? r_shadow_word[31:16] : r_shadow_word[15:0];
      r_frame_zf   <= r_shadow_zf;
      r_frame_of   <= r_shadow_of;
    end
  end

  // Current digit nibble and whether it plus all higher nibbles are zero
  always_comb begin
    w_nibble     = r_frame_word[3:0];
    w_upper_zero = 1'b0;
    case (r_digit_idx)
      2'd0: begin
        w_nibble     = r_frame_word[3:0];
        w_upper_zero = 1'b0;
      end
      2'd1: begin
        w_nibble     = r_frame_word[7:4];
        w_upper_zero = (r_frame_word[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble     = r_frame_word[11:8];
        w_upper_zero = (r_frame_word[15:8] == 8'h00);
      end
      default: begin
        w_nibble     = r_frame_word[15:12];
        w_upper_zero = (r_frame_word[15:12] == 4'h0);
      end
    endcase
  end

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Next segment/anode values; anodes go dark in the first cycle of every
  // slot so the previous digit's segments cannot ghost onto the new digit
  always_comb begin
    w_dp_n     = ~(((r_digit_idx == 2'd0) && r_frame_zf) ||
                   ((r_digit_idx == 2'd3) && r_frame_of));
    w_seg_next = {w_dp_n, (BLANK_LZ && w_upper_zero) ? SEG_BLANK : w_glyph};
    w_an_next  = (r_refresh_cnt == '0) ? AN_OFF : an_select(r_digit_idx);
  end

  // Registered display drive
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEG <= {1'b1, SEG_BLANK};
      AN  <= AN_OFF;
    end else begin
      SEG <= w_seg_next;
      AN  <= w_an_next;
    end
  end

endmodule : alu_display
`default_nettype wire

// File: tb/tb_alu_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_display
// Description : Self-checking bench for alu_display (REFRESH_DIV = 4). Two
//               instances share stimulus: one with leading-zero blanking and
//               one without. Expected frames are queued when a value is
//               driven and compared when a full scanned frame is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_display;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ALU_OUT;
  logic        ALU_ZF;
  logic        ALU_OF;
  logic        LOAD;
  logic        FREEZE;
  logic        HALF;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic [7:0]  SEG_NB;
  logic [3:0]  AN_NB;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] m;   // {digit3, digit2, digit1, digit0} with blanking
    logic [31:0] n;   // same frame without blanking
  } exp_t;

  exp_t sb_q[$];

  alu_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_ZF(ALU_ZF), .ALU_OF(ALU_OF),
    .LOAD(LOAD), .FREEZE(FREEZE), .HALF(HALF), .SEG(SEG), .AN(AN)
  );

  alu_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_ZF(ALU_ZF), .ALU_OF(ALU_OF),
    .LOAD(LOAD), .FREEZE(FREEZE), .HALF(HALF), .SEG(SEG_NB), .AN(AN_NB)
  );

  always #5 CLK = ~CLK;

  // Reference glyphs, active-low, [6:0] = g..a
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected SEG byte per digit for one displayed frame
  function automatic logic [31:0] exp_frame(input logic [15:0] w, input logic zf,
                                            input logic ovf, input bit blz);
    logic [31:0] r;
    logic [6:0]  g;
    logic        dp;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      g = glyph(w[4*i +: 4]);
      if (blz && i > 0 && (w >> (4*i)) == 16'h0) g = 7'h7F;
      dp = ~((i == 0 && zf) || (i == 3 && ovf));
      r[8*i +: 8] = {dp, g};
    end
    return r;
  endfunction

  task automatic push_exp(input logic [15:0] w, input logic zf, input logic ovf);
    exp_t e;
    e.m = exp_frame(w, zf, ovf, 1'b1);
    e.n = exp_frame(w, zf, ovf, 1'b0);
    sb_q.push_back(e);
  endtask

  task automatic drive_load(input logic [31:0] v, input logic zf, input logic ovf);
    @(posedge CLK); #1;
    ALU_OUT = v; ALU_ZF = zf; ALU_OF = ovf; LOAD = 1'b1;
    @(posedge CLK); #1;
    LOAD = 1'b0;
  endtask

  // Waits for the first active digit-0 sample after a dark sample, then
  // records one SEG byte per digit and counts anode samples off pattern.
  // Returns with the last (dark) sample of the frame just consumed.
  task automatic capture_frame(output logic [31:0] m, output logic [31:0] n,
                               output int an_bad);
    logic [3:0] prev;
    logic [3:0] exp_an;
    bit         found;
    found  = 1'b0;
    prev   = AN;
    m      = 'x;
    n      = 'x;
    an_bad = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge CLK);
      if (AN === 4'b1110 && prev === 4'hF) found = 1'b1;
      else prev = AN;
    end
    if (!found) begin
      an_bad = 100;
      return;
    end
    for (int s = 0; s < 16; s++) begin
      if (s > 0) @(negedge CLK);
      exp_an = (s % 4 == 3) ? 4'hF : ~(4'b0001 << (s / 4));
      if (AN !== exp_an)    an_bad++;
      if (AN_NB !== exp_an) an_bad++;
      if (s % 4 == 0) begin
        m[8*(s/4) +: 8] = SEG;
        n[8*(s/4) +: 8] = SEG_NB;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] gm, gn;
    int          bad;
    exp_t        e;
    #1;
    checks++;
    if (AN !== 4'hF) begin errors++; $display("FAIL reset_an got %h want f", AN); end
    checks++;
    if (SEG !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", SEG); end
    @(negedge CLK);
    RST = 1'b1;
    push_exp(16'h0000, 1'b0, 1'b0);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL reset_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL reset_frame_nb got %h want %h", gn, e.n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_an_scan got %0d bad want 0", bad); end
  endtask

  task automatic test_load_a5;
    logic [31:0] gm, gn;
    int          bad;
    exp_t        e;
    HALF = 1'b0;
    drive_load(32'h0000_00A5, 1'b0, 1'b0);
    push_exp(16'h00A5, 1'b0, 1'b0);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL a5_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL a5_frame_nb got %h want %h", gn, e.n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL a5_an_scan got %0d bad want 0", bad); end
  endtask

  task automatic test_half_select;
    logic [31:0] gm, gn;
    int          bad;
    exp_t        e;
    HALF = 1'b1;
    drive_load(32'h1234_0000, 1'b1, 1'b0);
    push_exp(16'h1234, 1'b1, 1'b0);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL half1_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL half1_frame_nb got %h want %h", gn, e.n); end
    HALF = 1'b0;
    push_exp(16'h0000, 1'b1, 1'b0);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL half0_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL half0_frame_nb got %h want %h", gn, e.n); end
  endtask

  task automatic test_of_blank;
    logic [31:0] gm, gn;
    int          bad;
    exp_t        e;
    drive_load(32'h0000_0000, 1'b0, 1'b1);
    push_exp(16'h0000, 1'b0, 1'b1);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL of_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL of_frame_nb got %h want %h", gn, e.n); end
  endtask

  task automatic test_freeze;
    logic [31:0] gm, gn;
    int          bad;
    exp_t        e;
    drive_load(32'h0000_0042, 1'b0, 1'b0);
    push_exp(16'h0042, 1'b0, 1'b0);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL pre_freeze_frame got %h want %h", gm, e.m); end
    @(posedge CLK); #1;
    FREEZE = 1'b1; LOAD = 1'b1; ALU_OUT = 32'hFFFF_FFFF; ALU_ZF = 1'b1; ALU_OF = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    LOAD = 1'b0;
    push_exp(16'h0042, 1'b0, 1'b0);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL freeze_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL freeze_frame_nb got %h want %h", gn, e.n); end
    FREEZE = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] gm, gn;
    int          bad;
    exp_t        e;
    HALF = 1'b0;
    @(posedge CLK); #1;
    LOAD = 1'b1; ALU_OUT = 32'h1111_6789; ALU_ZF = 1'b1; ALU_OF = 1'b0;
    @(posedge CLK); #1;
    ALU_OUT = 32'h0000_ABCD; ALU_ZF = 1'b0; ALU_OF = 1'b0;
    @(posedge CLK); #1;
    ALU_OUT = 32'hDEAD_0100; ALU_ZF = 1'b0; ALU_OF = 1'b1;
    @(posedge CLK); #1;
    LOAD = 1'b0;
    push_exp(16'h0100, 1'b0, 1'b1);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL b2b_lo_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL b2b_lo_frame_nb got %h want %h", gn, e.n); end
    HALF = 1'b1;
    push_exp(16'hDEAD, 1'b0, 1'b1);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL b2b_hi_frame got %h want %h", gm, e.m); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_an_scan got %0d bad want 0", bad); end
  endtask

  task automatic test_random_words;
    logic [31:0] gm, gn, w;
    logic        zf, ovf;
    int          bad;
    exp_t        e;
    for (int k = 0; k < 4; k++) begin
      w    = $urandom;
      zf   = 1'($urandom_range(0, 1));
      ovf  = 1'($urandom_range(0, 1));
      HALF = 1'($urandom_range(0, 1));
      drive_load(w, zf, ovf);
      push_exp(HALF ? w[31:16] : w[15:0], zf, ovf);
      capture_frame(gm, gn, bad);
      capture_frame(gm, gn, bad);
      e = sb_q.pop_front();
      checks++;
      if (gm !== e.m) begin errors++; $display("FAIL rand%0d_frame got %h want %h", k, gm, e.m); end
      checks++;
      if (gn !== e.n) begin errors++; $display("FAIL rand%0d_frame_nb got %h want %h", k, gn, e.n); end
    end
  endtask

  task automatic test_load_at_boundary;
    logic [31:0] gm, gn;
    int          bad;
    exp_t        e;
    HALF = 1'b0;
    drive_load(32'h0000_0077, 1'b0, 1'b0);
    push_exp(16'h0077, 1'b0, 1'b0);
    capture_frame(gm, gn, bad);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL bnd_old_frame got %h want %h", gm, e.m); end
    // Now one edge past a frame boundary B; the next boundary is B+16,
    // i.e. the 15th upcoming rising edge. Strobe LOAD onto exactly that edge.
    repeat (14) @(posedge CLK);
    #1;
    LOAD = 1'b1; ALU_OUT = 32'h0000_BEEF; ALU_ZF = 1'b0; ALU_OF = 1'b0;
    @(posedge CLK); #1;
    LOAD = 1'b0;
    push_exp(16'h0077, 1'b0, 1'b0);
    push_exp(16'hBEEF, 1'b0, 1'b0);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL bnd_same_edge_frame got %h want %h", gm, e.m); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bnd_an_scan got %0d bad want 0", bad); end
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL bnd_next_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL bnd_next_frame_nb got %h want %h", gn, e.n); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] gm, gn;
    logic [23:0] seq;
    int          bad;
    exp_t        e;
    capture_frame(gm, gn, bad);
    // Now one edge past boundary B; run to B+10 (digit 2, second cycle)
    repeat (9) @(posedge CLK);
    #2;
    checks++;
    if (AN !== 4'b1011) begin errors++; $display("FAIL mid_digit2_an got %h want b", AN); end
    RST = 1'b0;
    #1;
    checks++;
    if (AN !== 4'hF) begin errors++; $display("FAIL mid_reset_an got %h want f", AN); end
    checks++;
    if (SEG !== 8'hFF) begin errors++; $display("FAIL mid_reset_seg got %h want ff", SEG); end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    seq = 24'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      seq = {seq[19:0], AN};
    end
    checks++;
    if (seq !== 24'hFEEEFD) begin errors++; $display("FAIL mid_restart_an_seq got %h want feeefd", seq); end
    push_exp(16'h0000, 1'b0, 1'b0);
    capture_frame(gm, gn, bad);
    e = sb_q.pop_front();
    checks++;
    if (gm !== e.m) begin errors++; $display("FAIL mid_restart_frame got %h want %h", gm, e.m); end
    checks++;
    if (gn !== e.n) begin errors++; $display("FAIL mid_restart_frame_nb got %h want %h", gn, e.n); end
  endtask

  initial begin
    RST     = 1'b0;
    ALU_OUT = 32'h0;
    ALU_ZF  = 1'b0;
    ALU_OF  = 1'b0;
    LOAD    = 1'b0;
    FREEZE  = 1'b0;
    HALF    = 1'b0;
    repeat (3) @(posedge CLK);
    test_reset();
    test_load_a5();
    test_half_select();
    test_of_blank();
    test_freeze();
    test_back_to_back();
    test_random_words();
    test_load_at_boundary();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_display
`default_nettype wire
